// File: rtl/usr_shift_sequencer.sv
// Command sequencer for a universal shift register: turns one load/shift/rotate
// command at a time into the S/SDL/SDR/D drive pattern and pulses done.
module usr_shift_sequencer #(
    parameter int W  = 4,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [CW-1:0] cmd_amt,
    input  logic [W-1:0]  cmd_data,
    input  logic          cmd_fill,
    input  logic [W-1:0]  q_in,
    output logic [1:0]    s_out,
    output logic          sdl_out,
    output logic          sdr_out,
    output logic [W-1:0]  d_out,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [W-1:0]  data_q;
    logic          fill_q;

    logic accept;
    logic is_load;
    logic is_shift;

    assign accept   = cmd_valid & cmd_ready;
    assign is_load  = (cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR);
    assign is_shift = (cmd_op == OP_SHL) || (cmd_op == OP_SHR) ||
                      (cmd_op == OP_ROL) || (cmd_op == OP_ROR);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= OP_NOP;
            data_q <= '0;
            fill_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        data_q <= (cmd_op == OP_CLEAR) ? '0 : cmd_data;
                        fill_q <= cmd_fill;
                        cnt    <= is_shift ? cmd_amt : '0;
                        unique case (1'b1)
                            is_load:                    state <= ST_LOAD;
                            is_shift && cmd_amt != '0:  state <= ST_EXEC;
                            default:                    state <= ST_DONE;
                        endcase
                    end
                end
                ST_LOAD: state <= ST_DONE;
                ST_EXEC: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Rotate feedback comes straight from q_in so each edge moves exactly one bit.
    always_comb begin
        s_out     = 2'b00;
        sdl_out   = 1'b0;
        sdr_out   = 1'b0;
        d_out     = '0;
        cmd_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        unique case (state)
            ST_LOAD: begin
                s_out = 2'b11;
                d_out = data_q;
            end
            ST_EXEC: begin
                unique case (op_q)
                    OP_SHL: begin
                        s_out   = 2'b01;
                        sdl_out = fill_q;
                    end
                    OP_ROL: begin
                        s_out   = 2'b01;
                        sdl_out = q_in[W-1];
                    end
                    OP_SHR: begin
                        s_out   = 2'b10;
                        sdr_out = fill_q;
                    end
                    OP_ROR: begin
                        s_out   = 2'b10;
                        sdr_out = q_in[0];
                    end
                    default: s_out = 2'b00;
                endcase
            end
            default: s_out = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Scoreboard bench: sequencer drives a behavioural USR; each command's final Q
// and accept-to-done latency are predicted arithmetically and checked on done.
module tb_usr_shift_sequencer;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'b000;
    logic [CW-1:0] cmd_amt = '0;
    logic [W-1:0]  cmd_data = '0;
    logic          cmd_fill = 1'b0;
    logic [W-1:0]  usr_q = '0;
    logic [1:0]    s_out;
    logic          sdl_out;
    logic          sdr_out;
    logic [W-1:0]  d_out;
    logic          busy;
    logic          done;

    usr_shift_sequencer #(.W(W), .CW(CW)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
        .cmd_fill(cmd_fill), .q_in(usr_q), .s_out(s_out), .sdl_out(sdl_out),
        .sdr_out(sdr_out), .d_out(d_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural universal shift register driven by the sequencer.
    always @(posedge clk) begin
        case (s_out)
            2'b01: usr_q <= {usr_q[W-2:0], sdl_out};
            2'b10: usr_q <= {sdr_out, usr_q[W-1:1]};
            2'b11: usr_q <= d_out;
            default: ;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] model_q = '0;
    bit           started = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_q(input int op, input int amt,
                                           input int data, input int fill,
                                           input int q);
        int m = (1 << W) - 1;
        int k;
        case (op)
            1: return W'(data);
            6: return '0;
            2: if (amt >= W) return fill ? W'(m) : '0;
               else return W'(((q << amt) | (fill ? ((1 << amt) - 1) : 0)) & m);
            3: if (amt >= W) return fill ? W'(m) : '0;
               else return W'((q >> amt) | (fill ? (m ^ (m >> amt)) : 0));
            4: begin
                k = amt % W;
                return W'(((q << k) | (q >> (W - k))) & m);
            end
            5: begin
                k = amt % W;
                return W'(((q >> k) | (q << (W - k))) & m);
            end
            default: return W'(q);
        endcase
    endfunction

    function automatic int ref_lat(input int op, input int amt);
        if (op == 1 || op == 6) return 1;
        if (op >= 2 && op <= 5) return amt;
        return 0;
    endfunction

    // Leaves cmd_valid high after accept so consecutive commands test DONE gating.
    task automatic issue(input int op, input int amt, input int data, input int fill);
        int w = 0;
        exp_t e;
        @(negedge clk);
        cmd_op    = 3'(op);
        cmd_amt   = CW'(amt);
        cmd_data  = W'(data);
        cmd_fill  = fill[0];
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 want ready=1 op=%0d", op);
            cmd_valid = 1'b0;
            return;
        end
        e.q   = ref_q(op, amt, data, fill, int'(model_q));
        e.acc = cyc + 1;
        e.lat = ref_lat(op, amt);
        sb.push_back(e);
        model_q = e.q;
        @(posedge clk);
    endtask

    task automatic drain();
        int w = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while ((sb.size() != 0 || !cmd_ready) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || !cmd_ready) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want pending=0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (started && !clr) begin
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: got done=1 want done=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_q", usr_q, e.q);
                    chk("done_latency", cyc - e.acc, e.lat);
                end
            end
            if (s_out == 2'b01) chk("sdr_unused", sdr_out, 0);
            if (s_out == 2'b10) chk("sdl_unused", sdl_out, 0);
            chk("busy_vs_ready", busy, !cmd_ready);
            if (cmd_ready) begin
                chk("idle_s", s_out, 0);
                chk("idle_d", d_out, 0);
                chk("idle_serial", {sdl_out, sdr_out}, 0);
                chk("idle_done", done, 0);
            end
        end
    end

    logic [W-1:0] rol2;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s", s_out, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        clr = 1'b0;
        started = 1;

        issue(1, 0, 4'b1011, 0);
        issue(2, 2, 0, 1);
        issue(1, 0, 4'b1001, 0);
        issue(5, 5, 0, 0);
        issue(3, 0, 0, 1);
        issue(7, 3, 4'b0110, 1);
        issue(6, 0, 4'b1111, 0);
        issue(1, 0, 4'b0110, 0);
        drain();
        chk("ror_wrap_q", usr_q, ref_q(5, 5, 0, 0, 9) == 4'b1100 ? model_q : 4'hx);

        @(negedge clk);
        cmd_op    = 3'd4;
        cmd_amt   = CW'(3);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b1;
        #1;
        chk("clr_s", s_out, 0);
        chk("clr_ready", cmd_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        rol2 = ref_q(4, 2, 0, 0, int'(model_q));
        chk("clr_q_kept", usr_q, rol2);
        model_q = rol2;

        issue(1, 0, 4'b0101, 0);
        for (int i = 0; i < 40; i++)
            issue($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 15), $urandom_range(0, 1));
        drain();
        chk("final_q", usr_q, model_q);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
